atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
- Session-level FSM that sequences the combinational account authenticator: latches account number and PIN into it, samples its found/authenticated status, counts PIN retries and locks accounts after repeated failures.
- Sits between the card/keypad front end and the transaction datapath.
- The transaction datapath may only act while session_active is high.

Parameters:
- MAX_TRIES, 3, PIN attempts allowed per card insertion before the account is locked.
- NUM_ACCTS, 10, number of account slots; sets lock bitmap width.
- TIMEOUT_CYCLES, 1000, idle cycles in WAIT_PIN/SESSION before forced eject (only with the optional feature).

Ports:
- clk  in  1  Single system clock, rising edge.
- rst_n  in  1  Asynchronous, active-low reset.
- card_insert  in  1  One-cycle pulse: card present; sampled only in IDLE.
- acc_num_in  in  4  Account number from the card; sampled with card_insert.
- pin_in  in  16  Keypad PIN, decimal-encoded value; sampled with pin_valid.
- pin_valid  in  1  One-cycle pulse: PIN entry complete.
- cancel  in  1  User cancel; level or pulse.
- session_end  in  1  Transaction datapath finished; honoured in SESSION.
- admin_unlock  in  1  Pulse: clear lock bit admin_idx.
- admin_idx  in  4  Account index to unlock.
- auth_acc_num  out  4  Registered account number driven to the authenticator.
- auth_pin  out  16  Registered PIN driven to the authenticator.
- acc_found_stat  in  1  From authenticator; 1 = found.
- acc_auth_stat  in  1  From authenticator; 1 = PIN matches.
- acc_index_in  in  4  From authenticator; index of found account.
- acc_index_out  out  4  Latched index of the active account.
- session_active  out  1  High while in SESSION.
- attempts_left  out  $clog2(MAX_TRIES+1)  Remaining PIN attempts.
- auth_ok  out  1  Pulse: PIN accepted.
- auth_fail  out  1  Pulse: PIN rejected, retries remain.
- card_reject  out  1  Pulse: account not found.
- acct_locked  out  1  Pulse: account locked now, or already locked at insertion.
- card_eject  out  1  Pulse: card returned.
- timeout  out  1  Pulse: inactivity timeout.
- state_o  out  3  Current FSM state code.

Behaviour:
- Reset values:
  - All outputs 0; auth_acc_num = 0; auth_pin = 0.
  - Lock bitmap cleared; attempts_left = 0.
  - state IDLE.
  - Reset mid-session aborts with no eject pulse.
- State codes: IDLE=0, LOOKUP=1, WAIT_PIN=2, CHECK=3, SESSION=4, EJECT=5.
- IDLE:
  - card_insert latches acc_num_in into auth_acc_num, then -> LOOKUP.
  - All other inputs are ignored.
- LOOKUP (1 cycle, authenticator settles combinationally):
  - acc_found_stat = 0: card_reject pulse, -> EJECT.
  - Found and lock[acc_index_in] = 1: acct_locked pulse, -> EJECT.
  - Otherwise: acc_index_out <= acc_index_in, attempts_left <= MAX_TRIES, -> WAIT_PIN.
- WAIT_PIN:
  - cancel -> EJECT; cancel wins over a simultaneous pin_valid.
  - pin_valid latches pin_in into auth_pin, -> CHECK.
- CHECK (1 cycle, samples acc_auth_stat):
  - acc_auth_stat = 1: auth_ok pulse, -> SESSION.
  - acc_auth_stat = 0: attempts_left decrements.
    - Result 0: set lock[acc_index_out], acct_locked pulse, -> EJECT.
    - Result nonzero: auth_fail pulse, -> WAIT_PIN.
  - attempts_left never underflows.
- SESSION:
  - session_active = 1.
  - cancel or session_end -> EJECT.
- EJECT (1 cycle):
  - card_eject pulse; auth_pin cleared to 0; attempts_left cleared.
  - -> IDLE. card_insert in this cycle is ignored.
- Latency:
  - insert to WAIT_PIN: 2 cycles.
  - pin_valid to auth_ok/auth_fail: 2 cycles.
  - Pulses are registered and last exactly 1 cycle.
- Lock bitmap:
  - admin_unlock clears lock[admin_idx] in any state.
  - admin_idx >= NUM_ACCTS is ignored.
  - Unlock and lock on the same bit in the same cycle: lock wins.
  - Unlock does not affect a session in progress.
- auth_acc_num holds its value until the next insertion.

Optional Feature:
- Macro: ATM_TIMEOUT_EN.
- Defined:
  - Inactivity counter runs in WAIT_PIN and SESSION.
  - Counter clears on state entry, pin_valid, and session_end.
  - On reaching TIMEOUT_CYCLES-1: timeout pulse, -> EJECT. cancel in the same cycle gives the same transition, with timeout still pulsed.
  - Timeout in WAIT_PIN does not consume an attempt.
- Not defined:
  - No counter logic.
  - timeout tied to 0.
  - WAIT_PIN and SESSION wait indefinitely.

Test Plan:
- Insert acc 3, pin_valid 3456 -> auth_ok 2 cycles after pin_valid, session_active=1, acc_index_out=2; session_end -> card_eject, IDLE.
- Insert acc 12 -> card_reject at LOOKUP, card_eject next cycle, no WAIT_PIN entry.
- Insert acc 1, PINs 1111, 2222, 3333 -> auth_fail twice (attempts_left 2, 1), then acct_locked and eject; reinsert acc 1 -> acct_locked at LOOKUP.
- admin_unlock idx 0 after lock, reinsert acc 1 with PIN 1234 -> auth_ok; admin_idx 15 -> lock bitmap unchanged.
- In WAIT_PIN, assert cancel and pin_valid together -> EJECT, auth_pin=0, no CHECK.
- ATM_TIMEOUT_EN with TIMEOUT_CYCLES=8: insert acc 2, no PIN -> timeout pulse and eject after 8 cycles in WAIT_PIN; without macro, still in WAIT_PIN after 100 cycles.

Source files
------------

// File: rtl/atm_session_if.sv
// Bundle between the ATM session controller, the card/keypad front end and the
// combinational account authenticator. slave = controller side.
interface atm_session_if #(
  parameter int MAX_TRIES = 3
);
  localparam int AW = $clog2(MAX_TRIES + 1);

  logic          card_insert;
  logic [3:0]    acc_num_in;
  logic [15:0]   pin_in;
  logic          pin_valid;
  logic          cancel;
  logic          session_end;
  logic          admin_unlock;
  logic [3:0]    admin_idx;
  logic [3:0]    auth_acc_num;
  logic [15:0]   auth_pin;
  logic          acc_found_stat;
  logic          acc_auth_stat;
  logic [3:0]    acc_index_in;
  logic [3:0]    acc_index_out;
  logic          session_active;
  logic [AW-1:0] attempts_left;
  logic          auth_ok;
  logic          auth_fail;
  logic          card_reject;
  logic          acct_locked;
  logic          card_eject;
  logic          timeout;
  logic [2:0]    state_o;

  modport slave (
    input  card_insert, acc_num_in, pin_in, pin_valid, cancel, session_end,
           admin_unlock, admin_idx, acc_found_stat, acc_auth_stat, acc_index_in,
    output auth_acc_num, auth_pin, acc_index_out, session_active, attempts_left,
           auth_ok, auth_fail, card_reject, acct_locked, card_eject, timeout, state_o
  );

  modport master (
    output card_insert, acc_num_in, pin_in, pin_valid, cancel, session_end,
           admin_unlock, admin_idx, acc_found_stat, acc_auth_stat, acc_index_in,
    input  auth_acc_num, auth_pin, acc_index_out, session_active, attempts_left,
           auth_ok, auth_fail, card_reject, acct_locked, card_eject, timeout, state_o
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session FSM: card lookup, PIN retries with account lockout, session gating.
// Optional inactivity timeout in WAIT_PIN/SESSION enabled by `define ATM_TIMEOUT_EN.
module atm_session_ctrl #(
  parameter int MAX_TRIES      = 3,
  parameter int NUM_ACCTS      = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  atm_session_if.slave  bus
);
  localparam int AW = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_WAIT_PIN = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_SESSION  = 3'd4;
  localparam logic [2:0] S_EJECT    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [3:0]           acc_num_q, acc_num_d;
  logic [15:0]          pin_q, pin_d;
  logic [3:0]           idx_q, idx_d;
  logic [AW-1:0]        att_q, att_d, att_dec;
  logic [NUM_ACCTS-1:0] lock_q, lock_d;
  logic [15:0]          lock_ext;
  logic ok_q, ok_d, fail_q, fail_d, rej_q, rej_d, lkd_q, lkd_d, ej_q, ej_d, tmo_q, tmo_d;
  logic                 tmo_hit;

  // Zero-extend so any 4-bit authenticator index is a safe lookup (out of range = unlocked).
  assign lock_ext = 16'(lock_q);
  assign att_dec  = (att_q == '0) ? '0 : att_q - AW'(1);

`ifdef ATM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt_q;
  logic          t_run;

  assign t_run   = (state_q == S_WAIT_PIN) || (state_q == S_SESSION);
  assign tmo_hit = t_run && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tcnt_q <= '0;
    else if (t_run && !bus.pin_valid && !bus.session_end && state_d == state_q)
      tcnt_q <= tcnt_q + TW'(1);
    else
      tcnt_q <= '0;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_num_d = acc_num_q;
    pin_d     = pin_q;
    idx_d     = idx_q;
    att_d     = att_q;
    lock_d    = lock_q;
    ok_d = 1'b0; fail_d = 1'b0; rej_d = 1'b0; lkd_d = 1'b0; ej_d = 1'b0; tmo_d = 1'b0;

    for (int i = 0; i < NUM_ACCTS; i++)
      if (bus.admin_unlock && bus.admin_idx == 4'(i)) lock_d[i] = 1'b0;

    case (state_q)
      S_IDLE:
        if (bus.card_insert) begin
          acc_num_d = bus.acc_num_in;
          state_d   = S_LOOKUP;
        end
      S_LOOKUP:
        if (!bus.acc_found_stat) begin
          rej_d   = 1'b1;
          state_d = S_EJECT;
        end else if (lock_ext[bus.acc_index_in]) begin
          lkd_d   = 1'b1;
          state_d = S_EJECT;
        end else begin
          idx_d   = bus.acc_index_in;
          att_d   = AW'(MAX_TRIES);
          state_d = S_WAIT_PIN;
        end
      S_WAIT_PIN:
        if (bus.cancel || tmo_hit) begin
          tmo_d   = tmo_hit;
          state_d = S_EJECT;
        end else if (bus.pin_valid) begin
          pin_d   = bus.pin_in;
          state_d = S_CHECK;
        end
      S_CHECK:
        if (bus.acc_auth_stat) begin
          ok_d    = 1'b1;
          state_d = S_SESSION;
        end else begin
          att_d = att_dec;
          if (att_dec == '0) begin
            // Set after the unlock loop so a same-cycle unlock of this bit loses.
            for (int i = 0; i < NUM_ACCTS; i++)
              if (idx_q == 4'(i)) lock_d[i] = 1'b1;
            lkd_d   = 1'b1;
            state_d = S_EJECT;
          end else begin
            fail_d  = 1'b1;
            state_d = S_WAIT_PIN;
          end
        end
      S_SESSION:
        if (bus.cancel || bus.session_end || tmo_hit) begin
          tmo_d   = tmo_hit;
          state_d = S_EJECT;
        end
      S_EJECT: begin
        ej_d    = 1'b1;
        pin_d   = '0;
        att_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_num_q <= '0;
      pin_q     <= '0;
      idx_q     <= '0;
      att_q     <= '0;
      lock_q    <= '0;
      ok_q <= 1'b0; fail_q <= 1'b0; rej_q <= 1'b0; lkd_q <= 1'b0; ej_q <= 1'b0; tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_num_q <= acc_num_d;
      pin_q     <= pin_d;
      idx_q     <= idx_d;
      att_q     <= att_d;
      lock_q    <= lock_d;
      ok_q <= ok_d; fail_q <= fail_d; rej_q <= rej_d; lkd_q <= lkd_d; ej_q <= ej_d; tmo_q <= tmo_d;
    end
  end

  assign bus.auth_acc_num   = acc_num_q;
  assign bus.auth_pin       = pin_q;
  assign bus.acc_index_out  = idx_q;
  assign bus.session_active = (state_q == S_SESSION);
  assign bus.attempts_left  = att_q;
  assign bus.auth_ok        = ok_q;
  assign bus.auth_fail      = fail_q;
  assign bus.card_reject    = rej_q;
  assign bus.acct_locked    = lkd_q;
  assign bus.card_eject     = ej_q;
  assign bus.timeout        = tmo_q;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Self-checking bench for atm_session_ctrl with a behavioural authenticator and card-flow model.
module tb_atm_session_ctrl;
  localparam int MAXT = 3;
  localparam int NA   = 10;
`ifdef ATM_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atm_session_if #(.MAX_TRIES(MAXT)) bus ();
  atm_session_ctrl #(.MAX_TRIES(MAXT), .NUM_ACCTS(NA), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit locked [NA];

  // Account table: card numbers 1..NA map to slots 0..NA-1.
  function automatic logic [15:0] pin_of(input logic [3:0] a);
    case (a)
      4'd1:    return 16'd1234;
      4'd2:    return 16'd2345;
      4'd3:    return 16'd3456;
      default: return 16'(a) * 16'd1000 + 16'd7;
    endcase
  endfunction

  assign bus.acc_found_stat = (bus.auth_acc_num >= 4'd1) && (bus.auth_acc_num <= 4'(NA));
  assign bus.acc_index_in   = bus.auth_acc_num - 4'd1;
  assign bus.acc_auth_stat  = bus.acc_found_stat && (bus.auth_pin == pin_of(bus.auth_acc_num));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic admin(input logic [3:0] i);
    bus.admin_unlock = 1'b1; bus.admin_idx = i;
    tick();
    bus.admin_unlock = 1'b0;
    if (i < NA) locked[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.auth_acc_num, bus.auth_pin, bus.acc_index_out, bus.session_active, bus.attempts_left,
         bus.auth_ok, bus.auth_fail, bus.card_reject, bus.acct_locked, bus.card_eject,
         bus.timeout, bus.state_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: state=%0d pin=%h acc=%h", bus.state_o, bus.auth_pin, bus.auth_acc_num);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NA; i++) locked[i] = 1'b0;
    tick();
  endtask

  // Full card insertion driven from high-level intent; expectations come from the account rules.
  task automatic test_card_flow(input logic [3:0] acc, input int nwrong, input bit good,
                                input bit end_cancel, input int dwell, input bit unlock_at_lock);
    int left, k, idx;
    bit found, correct;
    logic [15:0] p;
    found = (acc >= 1) && (acc <= NA);
    idx   = int'(acc) - 1;
    bus.card_insert = 1'b1; bus.acc_num_in = acc;
    tick();
    bus.card_insert = 1'b0; bus.acc_num_in = $urandom_range(0, 15);
    checks++;
    if (bus.state_o !== 3'd1 || bus.auth_acc_num !== acc) begin
      errors++; $display("FAIL lookup_entry: state=%0d acc=%0d want 1/%0d", bus.state_o, bus.auth_acc_num, acc);
    end
    tick();
    if (!found || locked[idx]) begin
      checks++;
      if ({bus.state_o, bus.card_reject, bus.acct_locked} !== {3'd5, !found, found}) begin
        errors++; $display("FAIL lookup_outcome acc=%0d: st/rej/lkd=%0d/%b/%b want 5/%b/%b",
                           acc, bus.state_o, bus.card_reject, bus.acct_locked, !found, found);
      end
      tick();
      checks++;
      if ({bus.state_o, bus.card_eject, bus.card_reject, bus.acct_locked} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL lookup_eject acc=%0d: st=%0d ej=%b", acc, bus.state_o, bus.card_eject);
      end
      return;
    end
    checks++;
    if ({bus.state_o, bus.acc_index_out, bus.attempts_left} !== {3'd2, 4'(idx), 2'(MAXT)}) begin
      errors++; $display("FAIL wait_pin_entry: st=%0d idx=%0d att=%0d want 2/%0d/%0d",
                         bus.state_o, bus.acc_index_out, bus.attempts_left, idx, MAXT);
    end
    left = MAXT;
    k = 0;
    correct = 1'b0;
    while (k < nwrong + int'(good) && !correct) begin
      correct = (k >= nwrong);
      p = correct ? pin_of(acc) : pin_of(acc) ^ 16'($urandom_range(1, 65535));
      bus.pin_valid = 1'b1; bus.pin_in = p;
      tick();
      bus.pin_valid = 1'b0;
      checks++;
      if (bus.state_o !== 3'd3 || bus.auth_pin !== p) begin
        errors++; $display("FAIL check_entry: st=%0d pin=%0d want 3/%0d", bus.state_o, bus.auth_pin, p);
      end
      if (!correct && left == 1 && unlock_at_lock) begin
        bus.admin_unlock = 1'b1; bus.admin_idx = 4'(idx);
      end
      tick();
      bus.admin_unlock = 1'b0;
      if (correct) begin
        checks++;
        if ({bus.state_o, bus.auth_ok, bus.auth_fail, bus.session_active} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
          errors++; $display("FAIL auth_ok: st=%0d ok=%b fail=%b act=%b", bus.state_o, bus.auth_ok, bus.auth_fail, bus.session_active);
        end
      end else begin
        left--;
        checks++;
        if ({bus.state_o, bus.auth_fail, bus.acct_locked, bus.auth_ok, bus.attempts_left} !==
            {(left == 0) ? 3'd5 : 3'd2, left != 0, left == 0, 1'b0, 2'(left)}) begin
          errors++; $display("FAIL auth_reject left=%0d: st=%0d fail=%b lkd=%b att=%0d",
                             left, bus.state_o, bus.auth_fail, bus.acct_locked, bus.attempts_left);
        end
        if (left == 0) begin
          locked[idx] = 1'b1;
          tick();
          checks++;
          if ({bus.state_o, bus.card_eject, bus.auth_pin, bus.attempts_left} !== {3'd0, 1'b1, 16'd0, 2'd0}) begin
            errors++; $display("FAIL lock_eject: st=%0d ej=%b pin=%0d", bus.state_o, bus.card_eject, bus.auth_pin);
          end
          return;
        end
      end
      k++;
    end
    if (correct) begin
      repeat (dwell) begin
        tick();
        checks++;
        if ({bus.session_active, bus.auth_ok, bus.state_o} !== {1'b1, 1'b0, 3'd4}) begin
          errors++; $display("FAIL session_hold: act=%b ok=%b st=%0d", bus.session_active, bus.auth_ok, bus.state_o);
        end
      end
      if (end_cancel) bus.cancel = 1'b1; else bus.session_end = 1'b1;
    end else begin
      bus.cancel = 1'b1;
    end
    tick();
    bus.cancel = 1'b0; bus.session_end = 1'b0;
    checks++;
    if ({bus.state_o, bus.session_active} !== {3'd5, 1'b0}) begin
      errors++; $display("FAIL exit_to_eject: st=%0d act=%b", bus.state_o, bus.session_active);
    end
    tick();
    checks++;
    if ({bus.state_o, bus.card_eject, bus.auth_pin, bus.attempts_left} !== {3'd0, 1'b1, 16'd0, 2'd0}) begin
      errors++; $display("FAIL session_eject: st=%0d ej=%b pin=%0d att=%0d", bus.state_o, bus.card_eject, bus.auth_pin, bus.attempts_left);
    end
  endtask

  task automatic test_basic();
    test_card_flow(4'd3, 0, 1'b1, 1'b0, 2, 1'b0);
    test_card_flow(4'd12, 0, 1'b1, 1'b0, 0, 1'b0);
    tick();
    checks++;
    if (bus.card_eject !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL eject_pulse_width: ej=%b st=%0d want 0/0", bus.card_eject, bus.state_o);
    end
  endtask

  task automatic test_lock_unlock();
    test_card_flow(4'd1, 3, 1'b0, 1'b0, 0, 1'b0);
    test_card_flow(4'd1, 0, 1'b1, 1'b0, 0, 1'b0);
    admin(4'd15);
    test_card_flow(4'd1, 0, 1'b1, 1'b0, 0, 1'b0);
    admin(4'd0);
    test_card_flow(4'd1, 0, 1'b1, 1'b1, 1, 1'b0);
    test_card_flow(4'd4, 3, 1'b0, 1'b0, 0, 1'b1);
    test_card_flow(4'd4, 0, 1'b1, 1'b0, 0, 1'b0);
    admin(4'd3);
  endtask

  task automatic test_cancel_pin();
    bus.card_insert = 1'b1; bus.acc_num_in = 4'd2;
    tick();
    bus.card_insert = 1'b0;
    tick();
    bus.cancel = 1'b1; bus.pin_valid = 1'b1; bus.pin_in = pin_of(4'd2);
    tick();
    bus.cancel = 1'b0; bus.pin_valid = 1'b0;
    checks++;
    if ({bus.state_o, bus.auth_pin} !== {3'd5, 16'd0}) begin
      errors++; $display("FAIL cancel_wins: st=%0d pin=%0d want 5/0", bus.state_o, bus.auth_pin);
    end
    tick();
    checks++;
    if ({bus.state_o, bus.card_eject, bus.auth_ok} !== {3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL cancel_eject: st=%0d ej=%b", bus.state_o, bus.card_eject);
    end
  endtask

  task automatic test_timeout();
    bus.card_insert = 1'b1; bus.acc_num_in = 4'd2;
    tick();
    bus.card_insert = 1'b0;
    tick();
`ifdef ATM_TIMEOUT_EN
    repeat (TO - 1) tick();
    checks++;
    if ({bus.state_o, bus.timeout} !== {3'd2, 1'b0}) begin
      errors++; $display("FAIL timeout_early: st=%0d to=%b want 2/0", bus.state_o, bus.timeout);
    end
    tick();
    checks++;
    if ({bus.state_o, bus.timeout, bus.attempts_left} !== {3'd5, 1'b1, 2'(MAXT)}) begin
      errors++; $display("FAIL timeout_fire: st=%0d to=%b att=%0d", bus.state_o, bus.timeout, bus.attempts_left);
    end
`else
    repeat (100) tick();
    checks++;
    if ({bus.state_o, bus.timeout, bus.attempts_left} !== {3'd2, 1'b0, 2'(MAXT)}) begin
      errors++; $display("FAIL no_timeout: st=%0d to=%b att=%0d want 2/0/%0d", bus.state_o, bus.timeout, bus.attempts_left, MAXT);
    end
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
`endif
    tick();
    checks++;
    if ({bus.state_o, bus.card_eject, bus.timeout} !== {3'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL timeout_eject: st=%0d ej=%b to=%b", bus.state_o, bus.card_eject, bus.timeout);
    end
  endtask

  task automatic test_reset_mid();
    bus.card_insert = 1'b1; bus.acc_num_in = 4'd3;
    tick();
    bus.card_insert = 1'b0;
    tick();
    bus.pin_valid = 1'b1; bus.pin_in = pin_of(4'd3);
    tick();
    bus.pin_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.state_o, bus.session_active, bus.card_eject, bus.auth_pin, bus.auth_acc_num} !== '0) begin
      errors++; $display("FAIL reset_mid: st=%0d act=%b ej=%b", bus.state_o, bus.session_active, bus.card_eject);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NA; i++) locked[i] = 1'b0;
    tick();
    checks++;
    if (bus.card_eject !== 1'b0 || bus.state_o !== 3'd0) begin
      errors++; $display("FAIL reset_no_eject: ej=%b st=%0d", bus.card_eject, bus.state_o);
    end
  endtask

  task automatic test_random();
    int nw;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) admin(4'($urandom_range(0, 15)));
      nw = $urandom_range(0, 3);
      test_card_flow(4'($urandom_range(0, 15)), nw, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      tick();
    end
  endtask

  initial begin
    bus.card_insert = 1'b0; bus.acc_num_in = '0; bus.pin_in = '0; bus.pin_valid = 1'b0;
    bus.cancel = 1'b0; bus.session_end = 1'b0; bus.admin_unlock = 1'b0; bus.admin_idx = '0;
    test_reset();
    test_basic();
    test_lock_unlock();
    test_cancel_pin();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
